// File: rtl/op_scheduler_pkg.sv
// sched_pkg: shared FSM states, opcode indices and default data width for schedulers
package sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;
  localparam int DATA_W = 64;
endpackage

// File: rtl/op_scheduler_if.sv
// op_scheduler_if: requester and shared-unit signals; master is the client side, slave the scheduler
interface op_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 64
);
  localparam int SW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] req, ack, working;
  logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
  logic [DATA_W-1:0] result, unit_a, unit_b, unit_result;
  logic [SW-1:0] unit_sel;
  logic busy, unit_start, unit_done, timeout_err;
  modport master (
    output req, req_a, req_b, unit_done, unit_result,
    input ack, result, working, busy, unit_start, unit_sel, unit_a, unit_b, timeout_err
  );
  modport slave (
    input req, req_a, req_b, unit_done, unit_result,
    output ack, result, working, busy, unit_start, unit_sel, unit_a, unit_b, timeout_err
  );
endinterface

// File: rtl/op_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or after ptr
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any_req
);
  assign any_req = |req;
  always_comb begin
    grant = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) grant = W'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/op_scheduler.sv
// op_scheduler: round-robin owner of one shared arithmetic unit with a timeout guard
module op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = sched_pkg::DATA_W,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  op_scheduler_if.slave bus
);
  import sched_pkg::*;
  localparam int SW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  state_t state;
  logic [SW-1:0] rr_ptr, pick;
  logic any_req;
  logic [15:0] cnt;
  logic [NUM_REQ-1:0] grant_oh;
  rr_pick #(.N(NUM_REQ), .W(SW)) u_pick (
    .req(bus.req), .ptr(rr_ptr), .grant(pick), .any_req(any_req)
  );
  // unit_sel doubles as the grant register so opcode and owner can never diverge
  assign grant_oh = NUM_REQ'(1) << bus.unit_sel;
  assign bus.busy = state != IDLE;
  assign bus.working = bus.busy ? grant_oh : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      bus.unit_sel <= '0;
      bus.unit_a <= '0;
      bus.unit_b <= '0;
      bus.unit_start <= 1'b0;
      bus.ack <= '0;
      bus.result <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.unit_start <= 1'b0;
      bus.ack <= '0;
      bus.result <= '0;
      case (state)
        IDLE: if (any_req) begin
          bus.unit_sel <= pick;
          bus.unit_a <= bus.req_a[int'(pick)*DATA_W +: DATA_W];
          bus.unit_b <= bus.req_b[int'(pick)*DATA_W +: DATA_W];
          cnt <= '0;
          bus.unit_start <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (bus.unit_done) begin
          bus.result <= bus.unit_result;
          bus.ack <= grant_oh;
          state <= RESP;
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          bus.timeout_err <= 1'b1;
          bus.ack <= grant_oh;
          state <= RESP;
        end else cnt <= cnt + 16'd1;
        RESP: begin
          rr_ptr <= bus.unit_sel == SW'(NUM_REQ - 1) ? '0 : bus.unit_sel + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_op_scheduler.sv
// tb_op_scheduler: randomized self-checking bench with an emulated shared unit and an rr reference model
module tb_op_scheduler;
  localparam int N = 4, DW = 64, TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  op_scheduler_if #(.NUM_REQ(N), .DATA_W(DW)) bus();
  op_scheduler #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0, cyc = 0, ptr_m = 0;
  int unit_dly = 0, cd = 0;
  bit pend = 0, issue_strobe = 0;
  logic [63:0] ures;
  logic [63:0] opa [N];
  logic [63:0] opb [N];
  always @(posedge clk) cyc++;
  function automatic logic [63:0] model_op(int op, logic [63:0] a, logic [63:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      default: return b == 0 ? 64'd0 : a / b;
    endcase
  endfunction
  function automatic int pick_m(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  // emulated shared unit: done fires unit_dly cycles into WAIT, never when unit_dly < 0
  always @(negedge clk) begin
    bus.unit_done = 1'b0;
    bus.unit_result = '0;
    if (bus.unit_start) begin
      pend = unit_dly >= 0;
      cd = unit_dly;
      ures = model_op(int'(bus.unit_sel), bus.unit_a, bus.unit_b);
      if (issue_strobe) begin
        bus.unit_done = 1'b1;
        bus.unit_result = 64'h1234;
      end
    end else if (pend) begin
      if (cd == 0) begin
        bus.unit_done = 1'b1;
        bus.unit_result = ures;
        pend = 0;
      end else cd--;
    end
  end
  task automatic set_ops(int i, logic [63:0] a, logic [63:0] b);
    opa[i] = a;
    opb[i] = b;
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
  endtask
  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.unit_start;
    end
  endtask
  task automatic wait_ack(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = |bus.ack;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.ack, bus.working, bus.busy, bus.unit_start, bus.timeout_err, bus.unit_sel} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl ack=%b working=%b busy=%b start=%b terr=%b sel=%0d, want all 0", bus.ack, bus.working, bus.busy, bus.unit_start, bus.timeout_err, bus.unit_sel);
    end
    tests++;
    if ({bus.result, bus.unit_a, bus.unit_b} !== '0) begin
      fails++;
      $display("FAIL reset_data result=%h a=%h b=%h, want 0", bus.result, bus.unit_a, bus.unit_b);
    end
    rst = 1'b0;
    ptr_m = 0;
  endtask
  task automatic test_fairness;
    bit ok;
    int g, s, prev_s;
    prev_s = -1;
    for (int i = 0; i < N; i++) set_ops(i, 64'($urandom), 64'($urandom_range(1000, 1)));
    unit_dly = 0;
    @(negedge clk);
    bus.req = '1;
    for (int k = 0; k < 5; k++) begin
      g = pick_m(4'b1111, ptr_m);
      wait_start(ok);
      s = cyc;
      tests++;
      if (!ok || bus.unit_sel !== 2'(g) || g != k % N) begin
        fails++;
        $display("FAIL fair_grant op%0d started=%0b sel=%0d, want %0d", k, ok, bus.unit_sel, k % N);
      end
      if (prev_s >= 0) begin
        tests++;
        if (s - prev_s != 4) begin
          fails++;
          $display("FAIL fair_spacing op%0d start gap=%0d, want 4", k, s - prev_s);
        end
      end
      prev_s = s;
      wait_ack(ok);
      tests++;
      if (!ok || bus.ack !== 4'(1 << g) || bus.result !== model_op(g, opa[g], opb[g]) || cyc - s != 2) begin
        fails++;
        $display("FAIL fair_ack op%0d ack=%b result=%h lat=%0d, want ack=%b result=%h lat=2", k, bus.ack, bus.result, cyc - s, 4'(1 << g), model_op(g, opa[g], opb[g]));
      end
      ptr_m = (g + 1) % N;
      if (k == 4) bus.req = '0;
    end
    @(negedge clk);
    tests++;
    if (bus.ack !== '0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL fair_idle ack=%b busy=%b, want 0 0", bus.ack, bus.busy);
    end
  endtask
  task automatic test_single;
    bit ok;
    int s0;
    @(negedge clk);
    set_ops(0, 64'd5, 64'd7);
    bus.req = 4'b0001;
    unit_dly = 0;
    s0 = cyc;
    wait_start(ok);
    tests++;
    if (!ok || cyc - s0 != 1 || bus.unit_sel !== 2'd0 || bus.unit_a !== 64'd5 || bus.unit_b !== 64'd7 || bus.working !== 4'b0001) begin
      fails++;
      $display("FAIL single_issue cyc=%0d sel=%0d a=%0d b=%0d working=%b, want cyc=1 sel=0 a=5 b=7 working=0001", cyc - s0, bus.unit_sel, bus.unit_a, bus.unit_b, bus.working);
    end
    @(negedge clk);
    tests++;
    if (bus.unit_start !== 1'b0 || bus.working !== 4'b0001 || bus.ack !== '0) begin
      fails++;
      $display("FAIL single_wait start=%b working=%b ack=%b, want 0 0001 0000", bus.unit_start, bus.working, bus.ack);
    end
    @(negedge clk);
    tests++;
    if (cyc - s0 != 3 || bus.ack !== 4'b0001 || bus.result !== 64'd12 || bus.working !== 4'b0001) begin
      fails++;
      $display("FAIL single_ack cyc=%0d ack=%b result=%0d working=%b, want cyc=3 ack=0001 result=12 working=0001", cyc - s0, bus.ack, bus.result, bus.working);
    end
    bus.req = '0;
    ptr_m = 1;
    @(negedge clk);
    tests++;
    if (bus.ack !== '0 || bus.result !== '0 || bus.busy !== 1'b0 || bus.working !== '0) begin
      fails++;
      $display("FAIL single_after ack=%b result=%h busy=%b working=%b, want all 0", bus.ack, bus.result, bus.busy, bus.working);
    end
  endtask
  task automatic test_hold_operand;
    bit ok;
    @(negedge clk);
    set_ops(2, 64'd9, 64'd3);
    bus.req = 4'b0100;
    unit_dly = 2;
    wait_start(ok);
    @(negedge clk);
    bus.req_a[2*DW +: DW] = 64'd99;
    @(negedge clk);
    tests++;
    if (!ok || bus.unit_a !== 64'd9 || bus.unit_sel !== 2'd2) begin
      fails++;
      $display("FAIL hold_operand started=%0b unit_a=%0d sel=%0d, want 9 2", ok, bus.unit_a, bus.unit_sel);
    end
    wait_ack(ok);
    tests++;
    if (!ok || bus.ack !== 4'b0100 || bus.result !== 64'd27) begin
      fails++;
      $display("FAIL hold_ack ack=%b result=%0d, want 0100 27", bus.ack, bus.result);
    end
    bus.req = '0;
    ptr_m = 3;
  endtask
  task automatic test_issue_strobe;
    bit ok;
    int s;
    @(negedge clk);
    set_ops(1, 64'd0, 64'd1);
    bus.req = 4'b0010;
    unit_dly = 1;
    issue_strobe = 1;
    wait_start(ok);
    s = cyc;
    wait_ack(ok);
    issue_strobe = 0;
    tests++;
    if (!ok || bus.ack !== 4'b0010 || bus.result !== 64'hFFFF_FFFF_FFFF_FFFF || cyc - s != 3) begin
      fails++;
      $display("FAIL issue_strobe ack=%b result=%h lat=%0d, want 0010 ffffffffffffffff 3", bus.ack, bus.result, cyc - s);
    end
    bus.req = '0;
    ptr_m = 2;
  endtask
  task automatic test_done_at_limit;
    bit ok;
    int s;
    @(negedge clk);
    set_ops(3, 64'($urandom), 64'($urandom_range(500, 1)));
    bus.req = 4'b1000;
    unit_dly = TO - 1;
    wait_start(ok);
    s = cyc;
    wait_ack(ok);
    tests++;
    if (!ok || bus.ack !== 4'b1000 || bus.result !== model_op(3, opa[3], opb[3]) || bus.timeout_err !== 1'b0 || cyc - s != TO + 1) begin
      fails++;
      $display("FAIL done_at_limit ack=%b result=%h terr=%b lat=%0d, want 1000 %h 0 %0d", bus.ack, bus.result, bus.timeout_err, cyc - s, model_op(3, opa[3], opb[3]), TO + 1);
    end
    bus.req = '0;
    ptr_m = 0;
  endtask
  task automatic test_random;
    bit ok;
    int g, s, d;
    logic [N-1:0] reqv;
    logic [63:0] exp;
    reqv = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (!reqv[i] && $urandom_range(1, 0) == 1) begin
          set_ops(i, {32'($urandom), 32'($urandom)}, 64'($urandom_range(100000, 0)));
          reqv[i] = 1'b1;
        end
      if (reqv == '0) begin
        set_ops(k % N, 64'($urandom), 64'($urandom));
        reqv[k % N] = 1'b1;
      end
      bus.req = reqv;
      d = $urandom_range(TO - 1, 0);
      unit_dly = d;
      g = pick_m(reqv, ptr_m);
      exp = model_op(g, opa[g], opb[g]);
      wait_start(ok);
      s = cyc;
      tests++;
      if (!ok || bus.unit_sel !== 2'(g) || bus.unit_a !== opa[g] || bus.unit_b !== opb[g]) begin
        fails++;
        $display("FAIL rand_issue op%0d sel=%0d a=%h b=%h, want sel=%0d a=%h b=%h", k, bus.unit_sel, bus.unit_a, bus.unit_b, g, opa[g], opb[g]);
      end
      wait_ack(ok);
      tests++;
      if (!ok || bus.ack !== 4'(1 << g) || bus.result !== exp || cyc - s != d + 2) begin
        fails++;
        $display("FAIL rand_ack op%0d ack=%b result=%h lat=%0d, want ack=%b result=%h lat=%0d", k, bus.ack, bus.result, cyc - s, 4'(1 << g), exp, d + 2);
      end
      reqv[g] = 1'b0;
      bus.req = reqv;
      ptr_m = (g + 1) % N;
    end
    bus.req = '0;
    while (reqv != '0) begin
      g = pick_m(reqv, ptr_m);
      reqv[g] = 1'b0;
      ptr_m = (g + 1) % N;
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_timeout;
    bit ok;
    int s;
    @(negedge clk);
    set_ops(0, 64'd40, 64'd2);
    bus.req = 4'b0001;
    unit_dly = -1;
    ptr_m = 0;
    wait_start(ok);
    s = cyc;
    wait_ack(ok);
    tests++;
    if (!ok || bus.ack !== 4'b0001 || bus.result !== '0 || bus.timeout_err !== 1'b1 || cyc - s != TO + 1) begin
      fails++;
      $display("FAIL timeout ack=%b result=%h terr=%b lat=%0d, want 0001 0 1 %0d", bus.ack, bus.result, bus.timeout_err, cyc - s, TO + 1);
    end
    bus.req = '0;
    @(negedge clk);
    bus.req = 4'b0001;
    unit_dly = 0;
    wait_start(ok);
    wait_ack(ok);
    tests++;
    if (!ok || bus.result !== 64'd42 || bus.timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_sticky result=%0d terr=%b, want 42 1", bus.result, bus.timeout_err);
    end
    bus.req = '0;
    ptr_m = 1;
  endtask
  task automatic test_reset_mid_op;
    bit ok;
    @(negedge clk);
    set_ops(1, 64'd50, 64'd8);
    bus.req = 4'b0010;
    unit_dly = 2;
    wait_start(ok);
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (!ok || {bus.ack, bus.working, bus.busy, bus.unit_start, bus.timeout_err, bus.unit_sel} !== '0 || {bus.result, bus.unit_a, bus.unit_b} !== '0) begin
      fails++;
      $display("FAIL reset_mid ack=%b working=%b busy=%b terr=%b sel=%0d a=%h, want all 0", bus.ack, bus.working, bus.busy, bus.timeout_err, bus.unit_sel, bus.unit_a);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (bus.ack !== '0 || bus.busy !== 1'b0 || bus.result !== '0) begin
      fails++;
      $display("FAIL late_done ack=%b busy=%b result=%h, want 0 0 0", bus.ack, bus.busy, bus.result);
    end
    set_ops(0, 64'd3, 64'd4);
    bus.req = 4'b0011;
    unit_dly = 0;
    ptr_m = 0;
    wait_start(ok);
    tests++;
    if (!ok || bus.unit_sel !== 2'd0) begin
      fails++;
      $display("FAIL reset_ptr started=%0b sel=%0d, want 0", ok, bus.unit_sel);
    end
    wait_ack(ok);
    tests++;
    if (!ok || bus.ack !== 4'b0001 || bus.result !== 64'd7) begin
      fails++;
      $display("FAIL reset_next ack=%b result=%0d, want 0001 7", bus.ack, bus.result);
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_hold_operand();
    test_issue_strobe();
    test_done_at_limit();
    test_random();
    test_timeout();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
